joybus_device: RTL and testbench

- Device-side (controller) end of the N64 JOYBUS protocol. It is the responder to the team's JOYBUS host.
- Receives 8-bit host commands on the shared open-drain line and answers them.
- Answers info/reset with a 3-byte ID and poll with a 4-byte button word supplied by the board.
- Lets the FPGA emulate a controller, and gives a synthesizable counterpart for host bring-up and loopback testing.

---
 rtl/joybus_device.sv | 259 +++++++++++++++++++++++++
 tb/tb_joybus_device.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joybus_device.sv
// ---------------------------------------------------------------------------
// joybus_device
//
// Purpose:
//   Controller-side responder for the N64 JOYBUS single-wire protocol.
//   Receives an 8-bit host command followed by a host stop bit on the shared
//   open-drain line. The device then answers known commands on the same wire:
//     - info (8'h00) and reset (8'hFF) return the 3-byte ID 24'h050002.
//     - poll (8'h01) returns the 32-bit button word.
//   The button word is captured when the command is accepted.
//
// Line encoding (1 bit = 4 us):
//   '0' = 3 us low + 1 us high, '1' = 1 us low + 3 us high,
//   host stop = 1 us low, device stop = 2 us low.
//
// Ports:
//   clk        system clock (US_CYCLES cycles per microsecond)
//   rst_n      asynchronous active-low reset
//   JB_in      raw, asynchronous level of the JOYBUS line (1 = released)
//   JB_oe      1 = pull the line low, 0 = release (top level drives 1'bZ)
//   buttons    poll response word, sent MSB first
//   cmd        last command byte accepted with a valid stop bit
//   cmd_valid  one-cycle pulse when a command plus stop bit is accepted
//   resp_busy  high from cmd_valid until the device stop bit is released
//   rx_err     one-cycle pulse on a framing error or timeout
// ---------------------------------------------------------------------------
module joybus_device #(
  parameter int US_CYCLES       = 25,
  parameter int RESP_DELAY_US   = 2,
  parameter int IDLE_TIMEOUT_US = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        JB_in,
  output logic        JB_oe,
  input  logic [31:0] buttons,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic        resp_busy,
  output logic        rx_err
);

  // Cycle counter width. It must hold the largest receive-side count
  // (sample point + idle timeout) and the 4 us transmit bit period.
  localparam int CW = 16;

  // All receive-side times are measured from the detected falling edge
  // that started the current bit.
  localparam logic [CW-1:0] T_SAMPLE   = CW'(2 * US_CYCLES);
  localparam logic [CW-1:0] T_STUCK    = CW'(5 * US_CYCLES);
  // The idle timeout runs from the sample point, which is itself 2 us
  // after the edge.
  localparam logic [CW-1:0] T_TIMEOUT  = CW'((2 + IDLE_TIMEOUT_US) * US_CYCLES);
  // Terminal counts for the transmit side (count runs 0 .. N-1).
  localparam logic [CW-1:0] T_RESP_END = CW'(RESP_DELAY_US * US_CYCLES - 1);
  localparam logic [CW-1:0] T_BIT_END  = CW'(4 * US_CYCLES - 1);
  localparam logic [CW-1:0] T_STOP_END = CW'(2 * US_CYCLES - 1);
  localparam logic [CW-1:0] T_LOW0     = CW'(3 * US_CYCLES);
  localparam logic [CW-1:0] T_LOW1     = CW'(US_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_BIT,       // bit low phase, waiting for the sample point
    S_RX_GAP,       // between command bits, waiting for the next edge
    S_RX_STOP,      // after bit 8, waiting for the host stop-bit edge
    S_RX_STOP_SMP,  // inside the host stop bit, waiting for its sample
    S_RESP_WAIT,    // turnaround gap before the first response bit
    S_TX,           // driving response bits
    S_TX_STOP       // driving the 2 us device stop bit
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  logic [3:0]      rx_bits_q, rx_bits_d;
  logic [31:0]     tx_sr_q, tx_sr_d;
  logic [5:0]      tx_left_q, tx_left_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            resp_busy_q, resp_busy_d;
  logic            rx_err_q, rx_err_d;
  logic            jb_oe_q, jb_oe_d;

  logic            fall;
  logic            is_id_cmd;
  logic            is_poll_cmd;
  logic [CW-1:0]   low_len;

  // Falling edge of the synchronized line.
  assign fall        = prev_q & ~sync2_q;

  // Decode of the byte assembled so far (complete by the stop bit).
  assign is_id_cmd   = (rx_sr_q == 8'h00) || (rx_sr_q == 8'hFF);
  assign is_poll_cmd = (rx_sr_q == 8'h01);

  // Low time of the response bit currently at the head of the shifter.
  assign low_len     = tx_sr_q[31] ? T_LOW1 : T_LOW0;

  always_comb begin
    sync1_d     = JB_in;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    rx_sr_d     = rx_sr_q;
    rx_bits_d   = rx_bits_q;
    tx_sr_d     = tx_sr_q;
    tx_left_d   = tx_left_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    resp_busy_d = resp_busy_q;
    rx_err_d    = 1'b0;
    jb_oe_d     = jb_oe_q;

    unique case (state_q)
      S_IDLE: begin
        // Keep the counter parked so every bit starts counting from 0.
        cnt_d = '0;
        if (fall) begin
          rx_bits_d = '0;
          state_d   = S_RX_BIT;
        end
      end

      S_RX_BIT: begin
        if (cnt_q == T_SAMPLE) begin
          rx_sr_d   = {rx_sr_q[6:0], sync2_q};
          rx_bits_d = rx_bits_q + 4'd1;
          state_d   = (rx_bits_q == 4'd7) ? S_RX_STOP : S_RX_GAP;
        end
      end

      // The counter keeps running from the bit's falling edge, so the
      // stuck-low and idle-timeout checks use the same time base as the
      // sample point.
      S_RX_GAP, S_RX_STOP: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = (state_q == S_RX_GAP) ? S_RX_BIT : S_RX_STOP_SMP;
        end else if ((cnt_q == T_STUCK && !sync2_q) || cnt_q == T_TIMEOUT) begin
          rx_err_d = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_RX_STOP_SMP: begin
        if (cnt_q == T_SAMPLE) begin
          if (sync2_q) begin
            cmd_d       = rx_sr_q;
            cmd_valid_d = 1'b1;
            cnt_d       = '0;
            if (is_id_cmd) begin
              // The ID is left-aligned in the shifter so both response
              // lengths leave from bit 31.
              tx_sr_d     = {24'h050002, 8'h00};
              tx_left_d   = 6'd23;
              resp_busy_d = 1'b1;
              state_d     = S_RESP_WAIT;
            end else if (is_poll_cmd) begin
              tx_sr_d     = buttons;
              tx_left_d   = 6'd31;
              resp_busy_d = 1'b1;
              state_d     = S_RESP_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            rx_err_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end

      S_RESP_WAIT: begin
        if (cnt_q == T_RESP_END) begin
          cnt_d   = '0;
          jb_oe_d = 1'b1;
          state_d = S_TX;
        end
      end

      S_TX: begin
        if (cnt_q == T_BIT_END) begin
          // Every bit (and the stop bit) begins with the line pulled low.
          cnt_d   = '0;
          jb_oe_d = 1'b1;
          tx_sr_d = {tx_sr_q[30:0], 1'b0};
          if (tx_left_q == 6'd0) begin
            state_d = S_TX_STOP;
          end else begin
            tx_left_d = tx_left_q - 6'd1;
          end
        end else begin
          // Registered drive: decide for the next count value.
          jb_oe_d = ((cnt_q + CW'(1)) < low_len);
        end
      end

      S_TX_STOP: begin
        if (cnt_q == T_STOP_END) begin
          jb_oe_d     = 1'b0;
          resp_busy_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      // Preset to the released level so reset exit is not seen as an edge.
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      rx_bits_q   <= '0;
      tx_sr_q     <= '0;
      tx_left_q   <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      resp_busy_q <= 1'b0;
      rx_err_q    <= 1'b0;
      jb_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      rx_bits_q   <= rx_bits_d;
      tx_sr_q     <= tx_sr_d;
      tx_left_q   <= tx_left_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      resp_busy_q <= resp_busy_d;
      rx_err_q    <= rx_err_d;
      jb_oe_q     <= jb_oe_d;
    end
  end

  // Every output comes straight from a flop, so asserting reset releases
  // the line immediately.
  assign JB_oe     = jb_oe_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign resp_busy = resp_busy_q;
  assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_joybus_device.sv
// ---------------------------------------------------------------------------
// tb_joybus_device
//
// Purpose:
//   Drives host commands onto a modelled open-drain JOYBUS line. It decodes
//   the device's answer from the measured low pulse widths and compares the
//   command, the timing and the response against a small protocol model.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_joybus_device;

  localparam int US       = 25;
  localparam int RESP_US  = 2;
  localparam int TO_US    = 8;
  // Input latency: two synchronizer flops, the edge compare and the
  // registered output.
  localparam int LAT      = 4;

  logic        clk;
  logic        rst_n;
  logic        JB_in;
  logic        JB_oe;
  logic [31:0] buttons;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic        resp_busy;
  logic        rx_err;
  logic        host_low;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int txn_no = 0;

  // Open-drain wire: low if either side pulls.
  assign JB_in = ~(JB_oe | host_low);

  joybus_device #(
    .US_CYCLES      (US),
    .RESP_DELAY_US  (RESP_US),
    .IDLE_TIMEOUT_US(TO_US)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .JB_in    (JB_in),
    .JB_oe    (JB_oe),
    .buttons  (buttons),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .resp_busy(resp_busy),
    .rx_err   (rx_err)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------------
  // Line monitor: event timestamps and pulse-width decode of the answer.
  // Per-response state restarts on every cmd_valid.
  // ------------------------------------------------------------------
  int cv_count = 0, cv_cyc = 0, err_count = 0, err_cyc = 0, both_count = 0;
  int rise_cyc = 0, first_oe_cyc = 0, stop_cyc = 0, busy_fall_cyc = 0;
  int bad_len = 0;
  bit oe_started = 0, stop_seen = 0, busy_seen = 0;
  bit oe_prev = 0, busy_prev = 0;
  bit resp_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      oe_prev   = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (cmd_valid === 1'b1) begin
        cv_count++;
        cv_cyc     = cyc;
        resp_q.delete();
        oe_started = 0;
        stop_seen  = 0;
        busy_seen  = 0;
        bad_len    = 0;
      end
      if (rx_err === 1'b1) begin
        err_count++;
        err_cyc = cyc;
      end
      if (cmd_valid === 1'b1 && rx_err === 1'b1) both_count++;
      if (resp_busy === 1'b1) busy_seen = 1;
      if (JB_oe === 1'b1 && !oe_prev) begin
        rise_cyc = cyc;
        if (!oe_started) begin
          oe_started   = 1;
          first_oe_cyc = cyc;
        end
      end
      if (JB_oe === 1'b0 && oe_prev) begin
        if (cyc - rise_cyc == 3 * US)      resp_q.push_back(1'b0);
        else if (cyc - rise_cyc == US)     resp_q.push_back(1'b1);
        else if (cyc - rise_cyc == 2 * US) begin
          stop_seen = 1;
          stop_cyc  = cyc;
        end else bad_len++;
      end
      if (busy_prev && resp_busy === 1'b0) busy_fall_cyc = cyc;
      oe_prev   = (JB_oe === 1'b1);
      busy_prev = (resp_busy === 1'b1);
    end
  end

  // ------------------------------------------------------------------
  // Checking and reference model
  // ------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Protocol rule: which commands answer, with how many bits, and what.
  function automatic void model(input logic [7:0] c, input logic [31:0] b,
                                output int nbits, output logic [31:0] val);
    if (c == 8'h00 || c == 8'hFF) begin
      nbits = 24;
      val   = 32'h0005_0002;
    end else if (c == 8'h01) begin
      nbits = 32;
      val   = b;
    end else begin
      nbits = 0;
      val   = '0;
    end
  endfunction

  // ------------------------------------------------------------------
  // Host-side drivers (called at a negedge)
  // ------------------------------------------------------------------
  int last_fall = 0;
  int stop_fall = 0;

  task automatic send_bit(input bit b);
    host_low  = 1'b1;
    last_fall = cyc;
    repeat (b ? US : 3 * US) @(negedge clk);
    host_low = 1'b0;
    repeat (b ? 3 * US : US) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
    host_low  = 1'b1;
    stop_fall = cyc;
    repeat (US) @(negedge clk);
    host_low = 1'b0;
  endtask

  // One full host transaction checked against the model.
  task automatic do_cmd(input logic [7:0] c, input logic [31:0] b,
                        input bit mutate, input int quiet);
    int cv0, err0, k, nbits;
    logic [31:0] exp_val, got_val;
    cv0     = cv_count;
    err0    = err_count;
    buttons = b;
    model(c, b, nbits, exp_val);
    send_byte(c);
    k = 0;
    while (cv_count == cv0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_valid_seen", cv_count - cv0, 1);
    chk("cmd_valid_latency", cv_cyc - stop_fall, 2 * US + LAT);
    chk("cmd_value", cmd, c);
    got_val = '0;
    if (nbits != 0) begin
      k = 0;
      while (!stop_seen && k < 4000) begin
        @(negedge clk);
        k++;
        if (mutate && k == 300) buttons = ~b;
      end
      chk("resp_stop_seen", stop_seen, 1);
      chk("resp_first_oe", first_oe_cyc - cv_cyc, RESP_US * US);
      chk("resp_nbits", resp_q.size(), nbits);
      foreach (resp_q[i]) got_val = {got_val[30:0], resp_q[i]};
      chk("resp_value", got_val, exp_val);
      chk("resp_pulse_widths", bad_len, 0);
      chk("busy_fall_at_release", busy_fall_cyc, stop_cyc);
    end else begin
      repeat (quiet) @(negedge clk);
      chk("unknown_no_drive", oe_started, 0);
      chk("unknown_no_busy", busy_seen, 0);
      chk("unknown_cmd_held", cmd, c);
    end
    chk("no_rx_err", err_count - err0, 0);
    chk("err_valid_exclusive", both_count, 0);
    txn_no++;
    $display("txn %0d: cmd=%02h buttons=%08h mutate=%0d bits=%0d resp=%08h",
             txn_no, c, b, mutate, resp_q.size(), got_val);
    repeat (20) @(negedge clk);
  endtask

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    int cv0, err0, k;
    logic [7:0] rc;
    host_low = 1'b0;
    buttons  = '0;
    rst_n    = 1'b1;
    #5 rst_n = 1'b0;
    #1;
    chk("reset_oe", JB_oe, 0);
    chk("reset_cmd", cmd, 0);
    chk("reset_cmd_valid", cmd_valid, 0);
    chk("reset_busy", resp_busy, 0);
    chk("reset_rx_err", rx_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed: poll, info, reset command, unknown.
    do_cmd(8'h01, 32'hA5C3_0F81, 1'b0, 0);
    do_cmd(8'h00, $urandom, 1'b0, 0);
    do_cmd(8'hFF, $urandom, 1'b0, 0);
    do_cmd(8'h42, $urandom, 1'b0, 200 * US);

    // Truncated command: four bits, then the line stays released.
    cv0  = cv_count;
    err0 = err_count;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    k = 0;
    while (err_count == err0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("trunc_err_seen", err_count - err0, 1);
    chk("trunc_err_time", err_cyc - last_fall, 2 * US + TO_US * US + LAT);
    chk("trunc_no_valid", cv_count - cv0, 0);
    $display("txn %0d: truncated 4-bit command", ++txn_no);
    repeat (20) @(negedge clk);
    do_cmd(8'h01, $urandom, 1'b0, 0);

    // Stuck low for 10 us.
    cv0       = cv_count;
    err0      = err_count;
    host_low  = 1'b1;
    last_fall = cyc;
    repeat (10 * US) @(negedge clk);
    host_low = 1'b0;
    repeat (20) @(negedge clk);
    chk("stuck_err_seen", err_count - err0, 1);
    chk("stuck_err_time", err_cyc - last_fall, 5 * US + LAT);
    chk("stuck_no_valid", cv_count - cv0, 0);
    $display("txn %0d: line stuck low 10 us", ++txn_no);

    // Buttons cleared mid-response: the captured word is still sent.
    do_cmd(8'h01, 32'hFFFF_FFFF, 1'b1, 0);

    // Randomized transactions.
    for (int t = 0; t < 6; t++) begin
      case ($urandom_range(0, 3))
        0:       rc = 8'h00;
        1:       rc = 8'hFF;
        2:       rc = 8'h01;
        default: rc = 8'($urandom);
      endcase
      do_cmd(rc, $urandom, 1'($urandom_range(0, 1)), 40 * US);
    end

    // Reset during response bit 10.
    cv0     = cv_count;
    buttons = $urandom;
    send_byte(8'h01);
    k = 0;
    while ((cv_count == cv0 || resp_q.size() < 10) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (JB_oe !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("midtx_driving", JB_oe, 1);
    #5 rst_n = 1'b0;
    #1;
    chk("midtx_reset_oe", JB_oe, 0);
    chk("midtx_reset_busy", resp_busy, 0);
    chk("midtx_reset_cmd", cmd, 0);
    chk("midtx_reset_cmd_valid", cmd_valid, 0);
    chk("midtx_reset_rx_err", rx_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    $display("txn %0d: reset asserted during response bit 10", ++txn_no);
    repeat (20) @(negedge clk);
    do_cmd(8'h01, $urandom, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Run-length guard.
  initial begin
    #8000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
